// File: rtl/ram_arbiter_if.sv
// Shared types and the bundled requester/RAM signal set for ram_arbiter.
// The arbiter connects through the slave modport; the requesters and RAM side use master.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WAIT = 2'd1,
    RAM_DONE = 2'd2
  } ram_state_t;
endpackage

interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_ren;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_load;
  logic              i_done;

  logic              d_ren;
  logic [3:0]        d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_store;
  logic [DATA_W-1:0] d_load;
  logic              d_done;

  logic              ram_ren;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  ram_state_t        ram_state;

  modport slave (
    input  i_ren, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_state,
    output i_load, i_done, d_load, d_done, ram_ren, ram_wen, ram_addr, ram_store
  );

  modport master (
    output i_ren, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_state,
    input  i_load, i_done, d_load, d_done, ram_ren, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single-port block RAM: fetch vs. data memory.
// Grants alternate under contention; done/load are steered back to the winner.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           nrst,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IGNT,
    ARB_DGNT
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  arb_state_t state, state_nxt;
  grant_t     last_grant, last_grant_nxt;

  logic              i_pend;
  logic              d_pend;
  logic              ram_done;

  logic              ram_ren;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] i_load;
  logic [DATA_W-1:0] d_load;
  logic              i_done;
  logic              d_done;

  assign i_pend   = bus.i_ren;
  assign d_pend   = bus.d_ren | (|bus.d_wen);
  assign ram_done = (bus.ram_state == RAM_DONE);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ARB_IDLE;
      last_grant <= INSTR;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here is defaulted first, so no branch can infer a latch.
    state_nxt      = state;
    last_grant_nxt = last_grant;
    ram_ren        = 1'b0;
    ram_wen        = '0;
    ram_addr       = '0;
    ram_store      = '0;
    i_done         = 1'b0;
    i_load         = '0;
    d_done         = 1'b0;
    d_load         = '0;

    case (state)
      ARB_IDLE: begin
        // A tie goes to whoever was not served last.
        if (i_pend && d_pend) state_nxt = (last_grant == INSTR) ? ARB_DGNT : ARB_IGNT;
        else if (i_pend)      state_nxt = ARB_IGNT;
        else if (d_pend)      state_nxt = ARB_DGNT;
      end

      ARB_IGNT: begin
        if (!i_pend) begin
          state_nxt = ARB_IDLE;
        end else begin
          ram_ren  = bus.i_ren;
          ram_addr = bus.i_addr;
          if (ram_done) begin
            i_done         = 1'b1;
            i_load         = bus.ram_load;
            last_grant_nxt = INSTR;
            state_nxt      = d_pend ? ARB_DGNT : ARB_IDLE;
          end
        end
      end

      ARB_DGNT: begin
        if (!d_pend) begin
          state_nxt = ARB_IDLE;
        end else begin
          // Any byte enable turns the access into a write, even with d_ren set.
          ram_ren   = bus.d_ren & ~(|bus.d_wen);
          ram_wen   = bus.d_wen;
          ram_addr  = bus.d_addr;
          ram_store = bus.d_store;
          if (ram_done) begin
            d_done         = 1'b1;
            d_load         = bus.ram_load;
            last_grant_nxt = DATA;
            state_nxt      = i_pend ? ARB_IGNT : ARB_IDLE;
          end
        end
      end

      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign bus.ram_ren   = ram_ren;
  assign bus.ram_wen   = ram_wen;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_store = ram_store;
  assign bus.i_done    = i_done;
  assign bus.i_load    = i_load;
  assign bus.d_done    = d_done;
  assign bus.d_load    = d_load;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural block RAM of programmable latency.
// Expected completions are queued at issue time and matched against each done pulse.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    return (idx == 8'h40) ? 32'h0000_0013 : (32'hC0DE_0000 | {24'h0, idx});
  endfunction

  // Behavioural RAM: accepts in RAM_IDLE, waits ram_lat cycles, shows RAM_DONE for one cycle.
  int          ram_lat    = 0;
  logic        force_done = 1'b0;
  ram_state_t  rs;
  int          cnt;
  logic        wr_q;
  logic [7:0]  idx_q;
  bit   [31:0] mem     [256];
  bit          written [256];
  logic [31:0] rd_word;
  logic [31:0] base_word;
  logic [7:0]  acc_idx;

  assign acc_idx   = bus.ram_addr[9:2];
  assign base_word = written[acc_idx] ? mem[acc_idx] : init_word(acc_idx);
  assign rd_word   = written[idx_q] ? mem[idx_q] : init_word(idx_q);

  // NOTE: the array is deliberately kept out of reset; contents survive nrst like real block RAM.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rs    <= RAM_IDLE;
      cnt   <= 0;
      wr_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      case (rs)
        RAM_IDLE: if (bus.ram_ren || (|bus.ram_wen)) begin
          idx_q <= acc_idx;
          wr_q  <= |bus.ram_wen;
          cnt   <= ram_lat;
          if (|bus.ram_wen) begin
            for (int b = 0; b < 4; b++)
              mem[acc_idx][8*b +: 8] <= bus.ram_wen[b] ? bus.ram_store[8*b +: 8] : base_word[8*b +: 8];
            written[acc_idx] <= 1'b1;
          end
          rs <= (ram_lat == 0) ? RAM_DONE : RAM_WAIT;
        end
        RAM_WAIT: if (cnt <= 1) rs <= RAM_DONE; else cnt <= cnt - 1;
        default:  rs <= RAM_IDLE;
      endcase
    end
  end

  assign bus.ram_state = force_done ? RAM_DONE : rs;
  assign bus.ram_load  = (rs == RAM_DONE) ? (wr_q ? 32'h0 : rd_word) : 32'hFFFF_FFFF;

  // Scoreboard and idle-bus monitor.
  always @(negedge clk) begin
    if (nrst) begin
      check("one_done_at_a_time", {63'h0, bus.i_done & bus.d_done}, 64'h0);
      if (!bus.i_done) check("i_load_zero_without_done", bus.i_load, 0);
      if (!bus.d_done) check("d_load_zero_without_done", bus.d_load, 0);
      if (bus.i_done || bus.d_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {bus.i_done, bus.d_done}, 2'b00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_done_port", bus.d_done, e.is_d);
          check("sb_load", bus.d_done ? bus.d_load : bus.i_load, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_ren   = 1'b0;
    bus.i_addr  = '0;
    bus.d_ren   = 1'b0;
    bus.d_wen   = '0;
    bus.d_addr  = '0;
    bus.d_store = '0;
  endtask

  // Counts negedges from the current cycle (index 0) until the chosen done pulse.
  task automatic wait_done(input bit want_d, input int max_cyc, output int cyc);
    cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if ((want_d ? bus.d_done : bus.i_done) === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation reached 200000 time units, required $finish earlier");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int          cyc;
    int          nd;
    int          ni;
    int          n_done;
    logic [7:0]  hist;
    logic        rd;
    logic        ri;

    // Reset with every request line active: outputs must still be quiet.
    nrst        = 1'b0;
    bus.i_ren   = 1'b1;
    bus.i_addr  = '1;
    bus.d_ren   = 1'b1;
    bus.d_wen   = 4'hF;
    bus.d_addr  = '1;
    bus.d_store = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_ren", bus.ram_ren, 0);
    check("rst_ram_wen", bus.ram_wen, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_store", bus.ram_store, 0);
    check("rst_dones", {bus.i_done, bus.d_done}, 0);
    check("rst_loads", {bus.i_load, bus.d_load}, 0);
    clear_inputs();
    nrst = 1'b1;

    // Single fetch, LAT=0.
    tick();
    ram_lat    = 0;
    bus.i_ren  = 1'b1;
    bus.i_addr = 32'h100;
    sb.push_back(exp_t'{1'b0, 32'h0000_0013});
    @(negedge clk);
    check("fetch_c0_ram_ren", bus.ram_ren, 0);
    tick(); @(negedge clk);
    check("fetch_c1_ram_ren", bus.ram_ren, 1);
    check("fetch_c1_ram_addr", bus.ram_addr, 32'h100);
    check("fetch_c1_i_done", bus.i_done, 0);
    tick(); @(negedge clk);
    check("fetch_c2_i_done", bus.i_done, 1);
    check("fetch_c2_i_load", bus.i_load, 32'h13);
    check("fetch_c2_d_done", bus.d_done, 0);
    tick();
    bus.i_ren = 1'b0;
    @(negedge clk);
    check("fetch_c3_i_done", bus.i_done, 0);

    // Half-word store, LAT=1.
    tick();
    ram_lat     = 1;
    bus.d_wen   = 4'b0011;
    bus.d_addr  = 32'h2004;
    bus.d_store = 32'hDEAD_BEEF;
    sb.push_back(exp_t'{1'b1, 32'h0});
    tick(); @(negedge clk);
    check("store_c1_ram_wen", bus.ram_wen, 4'b0011);
    check("store_c1_ram_ren", bus.ram_ren, 0);
    check("store_c1_ram_store", bus.ram_store, 32'hDEAD_BEEF);
    check("store_c1_ram_addr", bus.ram_addr, 32'h2004);
    tick(); @(negedge clk);
    check("store_c2_ram_wen_held", bus.ram_wen, 4'b0011);
    check("store_c2_d_done", bus.d_done, 0);
    tick(); @(negedge clk);
    check("store_c3_d_done", bus.d_done, 1);
    check("store_c3_d_load", bus.d_load, 0);
    tick();
    bus.d_wen = '0;
    @(negedge clk);
    check("store_single_pulse", bus.d_done, 0);

    // Read back the merged word.
    tick();
    bus.d_ren  = 1'b1;
    bus.d_addr = 32'h2004;
    sb.push_back(exp_t'{1'b1, 32'hC0DE_BEEF});
    wait_done(1'b1, 20, cyc);
    check("readback_latency", cyc, 3);
    tick();
    bus.d_ren = 1'b0;

    // d_ren together with full byte enables is a write, LAT=0.
    tick();
    ram_lat     = 0;
    bus.d_ren   = 1'b1;
    bus.d_wen   = 4'hF;
    bus.d_addr  = 32'h300;
    bus.d_store = 32'h1234_5678;
    sb.push_back(exp_t'{1'b1, 32'h0});
    tick(); @(negedge clk);
    check("rw_c1_ram_ren", bus.ram_ren, 0);
    check("rw_c1_ram_wen", bus.ram_wen, 4'hF);
    wait_done(1'b1, 10, cyc);
    check("rw_done_next_cycle", cyc, 0);
    tick();
    bus.d_wen = '0;
    bus.d_ren = 1'b0;
    tick();
    bus.d_ren  = 1'b1;
    bus.d_addr = 32'h300;
    sb.push_back(exp_t'{1'b1, 32'h1234_5678});
    wait_done(1'b1, 10, cyc);
    check("rw_readback_latency", cyc, 2);
    tick();
    bus.d_ren = 1'b0;

    // A stray RAM_DONE while idle must not produce a completion.
    tick();
    force_done = 1'b1;
    @(negedge clk);
    check("idle_done_ignored", {bus.i_done, bus.d_done}, 0);
    check("idle_done_ram_ren", bus.ram_ren, 0);
    tick();
    force_done = 1'b0;
    @(negedge clk);
    check("idle_after_stray_done", {bus.ram_ren, bus.ram_wen}, 0);

    // Fresh reset, then a tie: data wins, instruction follows without a bubble.
    tick();
    nrst = 1'b0;
    tick();
    nrst       = 1'b1;
    bus.i_ren  = 1'b1;
    bus.i_addr = 32'h40;
    bus.d_ren  = 1'b1;
    bus.d_addr = 32'h80;
    sb.push_back(exp_t'{1'b1, init_word(8'h20)});
    sb.push_back(exp_t'{1'b0, init_word(8'h10)});
    @(negedge clk);
    check("tie_c0_idle", bus.ram_ren, 0);
    tick(); @(negedge clk);
    check("tie_c1_data_first", bus.ram_addr, 32'h80);
    tick(); @(negedge clk);
    check("tie_c2_d_done", bus.d_done, 1);
    tick();
    bus.d_ren = 1'b0;
    @(negedge clk);
    check("tie_c3_instr_b2b", {bus.ram_ren, bus.ram_addr}, {1'b1, 32'h40});
    tick(); @(negedge clk);
    check("tie_c4_i_done", bus.i_done, 1);
    tick();
    bus.i_ren = 1'b0;

    // Sustained contention over six transactions, LAT=1.
    tick();
    ram_lat    = 1;
    hist       = '0;
    nd         = 1;
    ni         = 1;
    n_done     = 0;
    bus.d_ren  = 1'b1;
    bus.d_addr = 32'h420;
    bus.i_ren  = 1'b1;
    bus.i_addr = 32'h600;
    sb.push_back(exp_t'{1'b1, init_word(8'h08)});
    sb.push_back(exp_t'{1'b0, init_word(8'h80)});
    for (int c = 0; c < 80 && n_done < 6; c++) begin
      @(negedge clk);
      rd = bus.d_done;
      ri = bus.i_done;
      if (rd || ri) begin
        n_done++;
        hist = {hist[6:0], rd};
      end
      tick();
      if (rd) begin
        if (nd < 3) begin
          bus.d_addr = 32'h420 + 32'(nd * 4);
          sb.push_back(exp_t'{1'b1, init_word(8'(8'h08 + nd))});
          nd++;
        end else begin
          bus.d_ren = 1'b0;
        end
      end
      if (ri) begin
        if (ni < 3) begin
          bus.i_addr = 32'h600 + 32'(ni * 4);
          sb.push_back(exp_t'{1'b0, init_word(8'(8'h80 + ni))});
          ni++;
        end else begin
          bus.i_ren = 1'b0;
        end
      end
    end
    check("contention_done_count", n_done, 6);
    check("contention_order_DIDIDI", hist[5:0], 6'b101010);

    // Reset in the middle of a LAT=2 data read: abort silently, then retry.
    tick();
    ram_lat    = 2;
    bus.d_ren  = 1'b1;
    bus.d_addr = 32'h2004;
    sb.push_back(exp_t'{1'b1, 32'hC0DE_BEEF});
    tick(); @(negedge clk);
    check("abort_c1_ram_ren", bus.ram_ren, 1);
    tick(); @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("abort_outputs_zero", {bus.ram_ren, bus.ram_wen, bus.ram_addr}, 0);
    check("abort_dones_zero", {bus.i_done, bus.d_done}, 0);
    sb.delete();
    tick();
    check("abort_no_d_done", bus.d_done, 0);
    nrst = 1'b1;
    sb.push_back(exp_t'{1'b1, 32'hC0DE_BEEF});
    wait_done(1'b1, 20, cyc);
    check("retry_latency_lat2", cyc, 4);
    tick();
    bus.d_ren = 1'b0;

    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
